rst_seq: RTL and testbench

Parametrised reset sequencer between the board-level clock/reset pins and the RISC5 system. Synchronises the external asynchronous active-low reset, holds the system in reset for a programmable number of cycles, then releases NCH reset channels one after another (CPU, memory, I/O, …) with a fixed stagger. An optional watchdog re-runs the sequence when software stops kicking it.

---
 rtl/rst_seq_pkg.sv | 30 +++
 rtl/rst_sync.sv | 21 ++
 rtl/rst_seq.sv | 134 +++++++++++++
 tb/tb_rst_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the rst_seq reset sequencer.
// Optional watchdog build macro: RST_SEQ_WATCHDOG_EN.
package rst_seq_pkg;

  localparam int unsigned WD_COUNT_W = 8;

  typedef enum logic [1:0] {
    StReset,
    StHold,
    StRun
  } state_e;

  // Counter must hold the last release offset and, with the watchdog, TIMEOUT.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned stagger,
                                            input int unsigned nch,
                                            input int unsigned timeout,
                                            input bit          wd_en);
    int unsigned top;
    top = hold + (nch - 1) * stagger;
    if (wd_en && (timeout > top)) begin
      top = timeout;
    end
    if (top < 1) begin
      return 1;
    end
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchroniser: asynchronous assert, synchronous deassert.
// Used by rst_seq (watchdog macro RST_SEQ_WATCHDOG_EN does not affect this block).
module rst_sync (
  input  logic clk_in,
  input  logic rst_in_n,
  output logic srst_n
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign srst_n = sync_q[1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronised hold, then staggered per-channel release.
// Define RST_SEQ_WATCHDOG_EN to build the watchdog that re-runs the sequence.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned HOLD    = 16,
  parameter int unsigned STAGGER = 4,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                  clk_in,
  input  logic                  rst_in_n,
  input  logic                  wd_kick,
  output logic [NCH-1:0]        rst_out_n,
  output logic                  ready,
  output logic                  wd_fired,
  output logic [WD_COUNT_W-1:0] wd_count
);

`ifdef RST_SEQ_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  localparam int unsigned CntW = cnt_width(HOLD, STAGGER, NCH, TIMEOUT, WdEn);
  localparam int unsigned Last = HOLD + (NCH - 1) * STAGGER;

  typedef logic [CntW-1:0] cnt_t;

  state_e                  state_q, state_d;
  cnt_t                    cnt_q, cnt_d;
  logic [NCH-1:0]          rel_q, rel_d;
  logic                    ready_q, ready_d;
  logic                    fired_q, fired_d;
  logic [WD_COUNT_W-1:0]   wdc_q, wdc_d;
  logic                    expire;
  logic                    srst_n;

`ifndef RST_SEQ_WATCHDOG_EN
  logic unused_kick;
  assign unused_kick = wd_kick;
`endif

  rst_sync u_rst_sync (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .srst_n   (srst_n)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    ready_d = ready_q;
    fired_d = fired_q;
    wdc_d   = wdc_q;
    expire  = 1'b0;

    unique case (state_q)
      // The edge that raised srst_n counts as offset 0, so HOLD is entered at 1.
      StReset: begin
        if (srst_n) begin
          state_d = StHold;
          cnt_d   = cnt_t'(1);
        end
      end
      StHold: begin
        cnt_d = cnt_q + 1'b1;
      end
      StRun: begin
`ifdef RST_SEQ_WATCHDOG_EN
        if (wd_kick) begin
          cnt_d = '0;
        end else if (32'(cnt_q) + 32'd1 >= TIMEOUT - 1) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = StReset;
      end
    endcase

    if (expire) begin
      state_d = StHold;
      cnt_d   = '0;
      rel_d   = '0;
      ready_d = 1'b0;
      fired_d = 1'b1;
      if (wdc_q != '1) begin
        wdc_d = wdc_q + 1'b1;
      end
    end else if (state_d == StHold) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (32'(cnt_d) >= HOLD + i * STAGGER) begin
          rel_d[i] = 1'b1;
        end
      end
      // Last channel out: RUN and ready in the same edge; counter becomes the watchdog.
      if (32'(cnt_d) >= Last) begin
        state_d = StRun;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= StReset;
      cnt_q   <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      fired_q <= 1'b0;
      wdc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      fired_q <= fired_d;
      wdc_q   <= wdc_d;
    end
  end

  assign rst_out_n = rel_q;
  assign ready     = ready_q;
  assign wd_fired  = fired_q;
  assign wd_count  = wdc_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq; watchdog scenarios run when RST_SEQ_WATCHDOG_EN is defined.
module tb_rst_seq;

  localparam int unsigned Nch  = 4;
  localparam int unsigned Hold = 16;
  localparam int unsigned Stag = 4;
  localparam int unsigned Tmo  = 100;
  localparam int unsigned Last = Hold + (Nch - 1) * Stag;
  localparam int unsigned Nch0 = 3;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       rdy;
  } ev_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic rst0_n = 1'b1;
  logic kick   = 1'b0;

  logic [Nch-1:0]  rst_out;
  logic            rdy, fired;
  logic [7:0]      wcnt;
  logic [Nch0-1:0] rst_out0;
  logic            rdy0, fired0;
  logic [7:0]      wcnt0;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  ev_t  q[$];
  ev_t  q0[$];
  logic [4:0] prev  = '0;
  logic [4:0] prev0 = '0;

  rst_seq #(
    .NCH     (Nch),
    .HOLD    (Hold),
    .STAGGER (Stag),
    .TIMEOUT (Tmo)
  ) dut (
    .clk_in    (clk),
    .rst_in_n  (rst_n),
    .wd_kick   (kick),
    .rst_out_n (rst_out),
    .ready     (rdy),
    .wd_fired  (fired),
    .wd_count  (wcnt)
  );

  rst_seq #(
    .NCH     (Nch0),
    .HOLD    (Hold),
    .STAGGER (0)
  ) dut0 (
    .clk_in    (clk),
    .rst_in_n  (rst0_n),
    .wd_kick   (1'b0),
    .rst_out_n (rst_out0),
    .ready     (rdy0),
    .wd_fired  (fired0),
    .wd_count  (wcnt0)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output changes are matched against queued events, in order.
  always @(negedge clk) begin
    logic [4:0] now;
    ev_t        e;
    now = {rdy, rst_out};
    if (now !== prev) begin
      if (q.size() == 0) begin
        check_eq("dut_unexpected_change", 32'(now), 32'(prev));
      end else begin
        e = q.pop_front();
        check_eq("dut_event_cycle", e.cyc, cyc);
        check_eq("dut_event_value", 32'(now), 32'({e.rdy, e.rst}));
      end
    end
    prev = now;
  end

  always @(negedge clk) begin
    logic [4:0] now;
    ev_t        e;
    now = {rdy0, 1'b0, rst_out0};
    if (now !== prev0) begin
      if (q0.size() == 0) begin
        check_eq("dut0_unexpected_change", 32'(now), 32'(prev0));
      end else begin
        e = q0.pop_front();
        check_eq("dut0_event_cycle", e.cyc, cyc);
        check_eq("dut0_event_value", 32'(now), 32'({e.rdy, e.rst}));
      end
    end
    prev0 = now;
  end

  // Returns 2 time units after posedge number n.
  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_seq(input int base);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < Nch; i++) begin
      m[i] = 1'b1;
      q.push_back('{base + Hold + i * Stag, m, (i == Nch - 1)});
    end
  endtask

  task automatic assert_rst();
    rst_n = 1'b0;
    q.push_back('{cyc, 4'b0000, 1'b0});
    #1;
    check_eq("async_rst_out", 32'(rst_out), 32'd0);
    check_eq("async_ready", 32'(rdy), 32'd0);
    check_eq("async_wd_fired", 32'(fired), 32'd0);
    check_eq("async_wd_count", 32'(wcnt), 32'd0);
  endtask

  task automatic release_rst(output int s);
    go_to(cyc + 1);
    rst_n = 1'b1;
    s = cyc + 2;
  endtask

  task automatic kick_at(input int k);
    go_to(k - 1);
    kick = 1'b1;
    go_to(k);
    kick = 1'b0;
  endtask

  initial begin
    int s;
    int z;
    int e;
    #1;
    rst_n  = 1'b0;
    rst0_n = 1'b0;
    #99;
    check_eq("reset_rst_out", 32'(rst_out), 32'd0);
    check_eq("reset_ready", 32'(rdy), 32'd0);
    check_eq("reset_wd_fired", 32'(fired), 32'd0);
    check_eq("reset_wd_count", 32'(wcnt), 32'd0);
    check_eq("reset_dut0_out", 32'(rst_out0), 32'd0);
    #45;
    rst_n  = 1'b1;
    rst0_n = 1'b1;
    s = cyc + 2;
    push_seq(s);
    q0.push_back('{s + Hold, 4'b0111, 1'b1});
    go_to(s + Hold - 1);
    check_eq("before_first_release", 32'(rst_out), 32'd0);
    go_to(s + Last + 1);
    check_eq("seq_ready", 32'(rdy), 32'd1);
    check_eq("seq_all_released", 32'(rst_out), 32'hf);
    check_eq("seq_wd_count", 32'(wcnt), 32'd0);
    check_eq("stagger0_ready", 32'(rdy0), 32'd1);

    // Reset in RUN, then again in the middle of HOLD.
    assert_rst();
    release_rst(s);
    q.push_back('{s + Hold, 4'b0001, 1'b0});
    go_to(s + Hold + 2);
    assert_rst();
    release_rst(s);
    push_seq(s);
    go_to(s + Last + 1);
    check_eq("restart_ready", 32'(rdy), 32'd1);
    z = s + Last;

`ifdef RST_SEQ_WATCHDOG_EN
    for (int k = 0; k < 6; k++) begin
      kick_at(z + 50);
      z = z + 50;
    end
    check_eq("kicked_wd_fired", 32'(fired), 32'd0);
    check_eq("kicked_ready", 32'(rdy), 32'd1);
    kick_at(z + Tmo - 1);
    z = z + Tmo - 1;
    go_to(z + 1);
    check_eq("kick_on_expiry_ready", 32'(rdy), 32'd1);
    check_eq("kick_on_expiry_fired", 32'(fired), 32'd0);

    e = z + Tmo - 1;
    q.push_back('{e, 4'b0000, 1'b0});
    push_seq(e);
    go_to(e + Last + 1);
    check_eq("expiry_wd_fired", 32'(fired), 32'd1);
    check_eq("expiry_wd_count", 32'(wcnt), 32'd1);
    z = e + Last;

    for (int k = 1; k < 300; k++) begin
      e = z + Tmo - 1;
      q.push_back('{e, 4'b0000, 1'b0});
      push_seq(e);
      go_to(e + Last + 1);
      z = e + Last;
    end
    check_eq("saturated_wd_count", 32'(wcnt), 32'd255);
    check_eq("saturated_wd_fired", 32'(fired), 32'd1);

    assert_rst();
    release_rst(s);
    push_seq(s);
    go_to(s + Last + 1);
    check_eq("after_rst_wd_fired", 32'(fired), 32'd0);
`else
    for (int k = 0; k < 5; k++) begin
      kick_at(cyc + 30);
    end
    go_to(z + 300);
    check_eq("terminal_run_ready", 32'(rdy), 32'd1);
    check_eq("terminal_run_out", 32'(rst_out), 32'hf);
    check_eq("nowd_wd_fired", 32'(fired), 32'd0);
    check_eq("nowd_wd_count", 32'(wcnt), 32'd0);
`endif

    go_to(cyc + 5);
    check_eq("dut_events_drained", q.size(), 32'd0);
    check_eq("dut0_events_drained", q0.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
